// File: rtl/pipe_if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_if_fetch_pkg
// Description : Shared state encodings and constants for the IF fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_if_fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] WORD_INC  = 32'd4;

endpackage
`default_nettype wire

// File: rtl/pipe_if_perf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_if_perf
// Description : Accepted-fetch and fetch-bubble counters; present only when
//               PIPE_IF_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef PIPE_IF_PERF_CNT_EN
module pipe_if_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_accept,
    input  logic        i_busy,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_bubble_cnt
);

    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else if (!i_stall) begin
            if (i_accept)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (i_busy)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt  = r_fetch_cnt;
    assign o_bubble_cnt = r_bubble_cnt;

endmodule
`endif
`default_nettype wire

// File: rtl/pipe_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pipe_if_fetch
// Description : Instruction-fetch stage: owns the PC, reads imem over req/ready
//               and presents npc/instruction (or a NOP) to the IF/ID register.
//               Optional counters enabled by PIPE_IF_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_if_fetch
    import pipe_if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_stall,
    input  logic        in_branch,
    input  logic [31:0] in_branch_target,
    output logic        out_imem_req,
    output logic [31:0] out_imem_addr,
    input  logic        in_imem_ready,
    input  logic [31:0] in_imem_rdata,
    output logic [31:0] out_npc,
    output logic [31:0] out_instruction,
    output logic        out_fetch_busy
`ifdef PIPE_IF_PERF_CNT_EN
    ,
    output logic [31:0] out_fetch_cnt,
    output logic [31:0] out_bubble_cnt
`endif
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_redirect;

    logic        w_present;
    logic        w_take_branch;
    logic [31:0] w_pc_inc;

    assign w_pc_inc      = r_pc + WORD_INC;
    assign w_take_branch = in_branch && !in_stall;
    assign w_present     = ((r_state == S_FETCH) && in_imem_ready) || (r_state == S_HOLD);

    // Presentation is combinational from ready/rdata; reset forces everything quiet.
    always_comb begin
        out_imem_req    = 1'b0;
        out_imem_addr   = r_pc;
        out_npc         = 32'd0;
        out_instruction = NOP_INSTR;
        out_fetch_busy  = 1'b0;
        if (!in_rst) begin
            out_imem_req   = (r_state == S_FETCH) || (r_state == S_KILL);
            out_fetch_busy = (r_state == S_KILL) || ((r_state == S_FETCH) && !in_imem_ready);
            if (w_present) begin
                out_npc         = w_pc_inc;
                out_instruction = (r_state == S_HOLD) ? r_buf : in_imem_rdata;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_buf      <= NOP_INSTR;
            r_redirect <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (in_imem_ready) begin
                        if (in_stall) begin
                            r_buf   <= in_imem_rdata;
                            r_state <= S_HOLD;
                        end else if (in_branch) begin
                            r_pc <= in_branch_target;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end else if (w_take_branch) begin
                        r_redirect <= in_branch_target;
                        r_state    <= S_KILL;
                    end
                end
                S_HOLD: begin
                    if (!in_stall) begin
                        r_pc    <= in_branch ? in_branch_target : w_pc_inc;
                        r_state <= S_FETCH;
                    end
                end
                S_KILL: begin
                    // A branch arriving with the stale response still wins.
                    if (w_take_branch)
                        r_redirect <= in_branch_target;
                    if (in_imem_ready) begin
                        r_pc    <= w_take_branch ? in_branch_target : r_redirect;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

`ifdef PIPE_IF_PERF_CNT_EN
    logic w_accept;
    assign w_accept = !in_rst && w_present && !in_stall && !in_branch;

    pipe_if_perf u_perf (
        .clk          (in_clk),
        .rst          (in_rst),
        .i_stall      (in_stall),
        .i_accept     (w_accept),
        .i_busy       (out_fetch_busy),
        .o_fetch_cnt  (out_fetch_cnt),
        .o_bubble_cnt (out_bubble_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: doc/pipe_if_fetch.md
# pipe_if_fetch

Instruction-fetch stage that produces the `npc`/`instruction` pair consumed by the IF/ID pipeline register. It owns the PC, issues word reads to instruction memory over a req/ready handshake, and obeys the same stall and branch-flush controls the IF/ID register sees. When memory cannot deliver, it presents a NOP so the IF/ID register fills with a bubble.

## Interface
Parameters:
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset.

Ports:
- `in_clk`  input  1  sole clock, rising edge.
- `in_rst`  input  1  reset; one clock; synchronous, active-high.
- `in_stall`  input  1  downstream stall; same signal as the IF/ID stall.
- `in_branch`  input  1  redirect request; same signal as the IF/ID flush.
- `in_branch_target`  input  32  redirect PC, word aligned.
- `out_imem_req`  output  1  read request to instruction memory.
- `out_imem_addr`  output  32  read address; equals the PC.
- `in_imem_ready`  input  1  read data valid this cycle.
- `in_imem_rdata`  input  32  instruction word.
- `out_npc`  output  32  PC+4 of the presented instruction; 0 with a NOP.
- `out_instruction`  output  32  presented instruction; 32'h0 (NOP) when none.
- `out_fetch_busy`  output  1  high when no instruction is presented because memory is pending.

## Operation
- States: `S_FETCH` (request for `pc` outstanding), `S_HOLD` (word buffered, waiting for stall release), `S_KILL` (old request still outstanding after a redirect; response will be discarded).
- Reset: `pc`=`RESET_PC`, state `S_FETCH`, buffer=0, redirect register=0. While `in_rst` is high: `out_imem_req`=0, `out_instruction`=0, `out_npc`=0, `out_fetch_busy`=0.
- `out_imem_req`=1 in `S_FETCH` and `S_KILL`; 0 in `S_HOLD`. `out_imem_addr` holds stable while req=1 and ready=0.
- Presented word: `S_FETCH` with ready → `in_imem_rdata`; `S_HOLD` → buffer; otherwise 0. `out_npc`=`pc`+4 (mod 2^32) whenever a word is presented, else 0.
- `S_FETCH` with ready and stall=0, branch=0: `pc`←`pc`+4, stay in `S_FETCH`.
- `S_FETCH` with ready and stall=1: buffer←rdata, go to `S_HOLD`, `pc` is unchanged.
- `S_HOLD` with stall=0, branch=0: `pc`←`pc`+4, go to `S_FETCH`.
- Branch honoured only when stall=0. While stalled, branch is ignored, matching IF/ID behaviour, and the control unit must hold it until release.
- Branch in `S_FETCH` with ready, or in `S_HOLD`: `pc`←target, drop the presented word, go to `S_FETCH`.
- Branch in `S_FETCH` without ready: redirect←target, go to `S_KILL`.
- `S_KILL`: presents a NOP. On ready, discard rdata, `pc`←redirect, go to `S_FETCH`. A second branch in `S_KILL` overwrites redirect; last one wins.
- `out_fetch_busy`=1 in `S_KILL`, or in `S_FETCH` without ready.
- `in_rst` mid-transaction aborts unconditionally. Any in-flight response is ignored. Memory must tolerate a dropped request.

## Timing
- Zero-wait memory (ready is combinational in the request cycle) gives 1 instruction/cycle. The presented word reaches the IF/ID outputs at the next edge.
- Presentation path from `in_imem_ready`/`in_imem_rdata` to outputs is combinational. State, `pc`, buffer and redirect are registered.
- Redirect penalty with zero-wait memory: 1 bubble, the flushed slot in IF/ID. With N wait states pending at the branch, add N further NOP cycles in `S_KILL`.
- First request is issued in the cycle after `in_rst` deasserts, to `RESET_PC`.

## Configuration
- `PIPE_IF_PERF_CNT_EN` defined: adds outputs `out_fetch_cnt` (32, increments when a presented word is accepted, i.e. stall=0, branch=0) and `out_bubble_cnt` (32, increments each cycle `out_fetch_busy`=1). Both are 0 on reset, wrap at 2^32, and hold while `in_stall`=1.
- Not defined: ports and counters are absent. Otherwise the behaviour is identical.

## Structure
- Shared package/header: state encodings `S_FETCH`/`S_HOLD`/`S_KILL`, `NOP_INSTR`=32'h0, word-increment constant 4.
- Optional sub-module `pipe_if_perf` holds both counters and is instantiated only under `PIPE_IF_PERF_CNT_EN`.

## Test plan
- Reset, then zero-wait memory returning addr-derived words, with stall=0 → `out_npc` = 0x00400004, 0x00400008, … on consecutive cycles, and `out_imem_addr` advances by 4 per cycle.
- Stall for 3 cycles while ready=1 at `pc`=0x00400010 → one request, then `S_HOLD`. Same word and `out_npc`=0x00400014 are presented for 3 cycles, and `pc` advances only after release.
- Branch to 0x00400100 while memory stalls 2 cycles on 0x00400020 → NOP for 3 cycles, stale word never presented, next request addr 0x00400100.
- Branch asserted with stall=1 → ignored, `pc` unchanged. Same branch with stall=0 next cycle → `pc`=target.
- `in_rst` asserted in `S_KILL` → the next cycle's request is to `RESET_PC`, and the late ready/rdata is ignored.
- With `PIPE_IF_PERF_CNT_EN`: 10 accepted fetches plus 4 wait cycles → `out_fetch_cnt`=10, `out_bubble_cnt`=4.
